instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the word address of the first fetch after reset.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the width of the PC and of imem_addr.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-006 SHALL have port imem_addr, output, ADDR_W, word address being fetched.
REQ-007 SHALL have port imem_ack, input, 1, memory has returned data on imem_rdata in this cycle.
REQ-008 SHALL have port imem_rdata, input, 32, instruction word, valid only when imem_ack=1.
REQ-009 SHALL have port instr_valid, output, 1, instr and pc_out hold a fetched instruction.
REQ-010 SHALL have port instr_ready, input, 1, the downstream PC/execute stage accepts the instruction.
REQ-011 SHALL have port instr, output, 32, the registered instruction word.
REQ-012 SHALL have port pc_out, output, ADDR_W, the word address of instr.
REQ-013 SHALL have port branch_taken, input, 1, redirect request (branch & zero_flag from the PC stage).
REQ-014 SHALL have port branch_target, input, ADDR_W, redirect word address (pc+1+offset, computed downstream).
REQ-015 SHALL have port fetch_count, output, 32, the number of instructions accepted.

Function
REQ-016 SHALL implement a two-state FSM with states FETCH and HOLD.
REQ-017 In FETCH: imem_req=1, imem_addr=pc_reg, instr_valid=0.
REQ-018 In HOLD: imem_req=0, instr_valid=1.
REQ-019 In FETCH with imem_ack=1: SHALL capture imem_rdata into instr, set pc_out=pc_reg, and move to HOLD on the next edge (one-cycle latency, ack cycle N gives instr_valid in cycle N+1).
REQ-020 In FETCH with imem_ack=0: SHALL stay in FETCH and keep imem_addr stable.
REQ-021 SHALL accept imem_ack in the same cycle that imem_req first rises (zero-wait memory).
REQ-022 SHALL ignore imem_ack whenever imem_req=0.
REQ-023 In HOLD with instr_ready=0: SHALL hold instr, pc_out and instr_valid stable.
REQ-024 In HOLD with instr_ready=1 (acceptance): SHALL move to FETCH.
REQ-025 On acceptance: pc_reg SHALL load branch_target if branch_taken=1, else pc_out+1.
REQ-026 On acceptance: fetch_count SHALL increment by 1.
REQ-027 branch_taken and branch_target SHALL be sampled only in the acceptance cycle and ignored otherwise.
REQ-028 PC increment SHALL be modulo 2^ADDR_W: all-ones + 1 gives 0, with no error flag.
REQ-029 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 Throughput SHALL be at most one instruction per 2 cycles; there SHALL be no back-to-back fetches without passing through HOLD.
REQ-031 instr, pc_out and fetch_count SHALL be registered outputs.
REQ-032 imem_req and instr_valid SHALL be decoded from state only, with no combinational path from any input.

Reset
REQ-033 On reset=1 at a clock edge: state=FETCH, pc_reg=RESET_PC, instr=0, pc_out=0, fetch_count=0.
REQ-034 The first cycle after reset deasserts SHALL show imem_req=1 and imem_addr=RESET_PC.
REQ-035 Reset SHALL take priority over ack, ready and branch in the same cycle.
REQ-036 Reset mid-operation in FETCH or HOLD SHALL abandon the outstanding request or instruction without incrementing fetch_count.
REQ-037 An imem_ack arriving in the reset cycle SHALL be discarded.

Verification
REQ-038 Zero-wait memory, instr_ready=1 constantly, RESET_PC=0 -> imem_addr 0,1,2,3 on alternate cycles; fetch_count=4 after 8 cycles.
REQ-039 imem_ack delayed 3 cycles at addr 5 -> imem_addr stays 5 for 4 cycles; instr_valid rises the cycle after ack with instr=imem_rdata.
REQ-040 instr_ready held 0 for 5 cycles in HOLD -> instr, pc_out unchanged, imem_req=0 throughout, fetch_count unchanged.
REQ-041 Accept at pc_out=7 with branch_taken=1, branch_target=20 -> next imem_addr=20; branch_taken=1 in FETCH or in non-accepting HOLD -> no effect.
REQ-042 RESET_PC=32'hFFFF_FFFF, accept with branch_taken=0 -> next imem_addr=0.
REQ-043 Reset asserted in HOLD with instr_ready=1 and in FETCH with imem_ack=1 -> next cycle FETCH at RESET_PC, fetch_count=0, instr_valid=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: a two-state request/hold engine that reads one word from
// instruction memory, presents it downstream, and redirects the PC when the word is accepted.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       fetch_count,
  output logic              fsm_state
);

  // Handshakes: the memory transfer happens in a cycle with imem_req=1 and imem_ack=1.
  // The downstream transfer happens in a cycle with instr_valid=1 and instr_ready=1.
  // While a side waits, the other side's request and payload stay stable.

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_RESET = RESET_PC[ADDR_W-1:0];

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic              capture;
  logic              accept;

  // capture and accept are gated by state, so an ack seen in HOLD is ignored.
  assign capture = (state == FETCH) && imem_ack;
  assign accept  = (state == HOLD) && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (imem_ack)    state_next = HOLD;
      HOLD:    if (instr_ready) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == HOLD);
    imem_addr   = pc_reg;
    fsm_state   = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= PC_RESET;
      instr       <= 32'd0;
      pc_out      <= '0;
      fetch_count <= 32'd0;
    end else begin
      if (capture) begin
        instr  <= imem_rdata;
        pc_out <= pc_reg;
      end
      // Branch inputs are looked at only in the acceptance cycle; the increment wraps.
      if (accept) begin
        pc_reg      <= branch_taken ? branch_target : (pc_out + PC_ONE);
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
